mips_mc: RTL and testbench

Multi-cycle MIPS core: the next generation of the single-cycle top. It executes the same instruction subset through a five-state FSM over one shared instruction/data memory port with a ready handshake, so it tolerates wait-state memory. It is the top-level CPU. It owns the PC, IR, register file, ALU and control FSM, and exposes a write-back trace port for the grading bench.

---
 rtl/mips_mc_pkg.sv | 45 ++++
 rtl/mips_mc_rf.sv | 28 ++
 rtl/mips_mc.sv | 152 +++++++++++++++
 tb/tb_mips_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings, FSM state and ALU operation types for the multi-cycle MIPS core.
package mips_mc_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
  typedef enum logic [2:0] {ADD, SUB, OR, LUI, PASS} alu_op_e;
  typedef enum logic [3:0] {
    I_RTYPE, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL, I_JR, I_NOP
  } instr_e;

  // Anything not in the supported subset classifies as I_NOP and retires after DECODE.
  function automatic instr_e classify(input logic [5:0] op, input logic [5:0] funct);
    instr_e k;
    k = I_NOP;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLL) k = I_RTYPE;
        else if (funct == FN_JR) k = I_JR;
      end
      OP_ORI:  k = I_ORI;
      OP_LUI:  k = I_LUI;
      OP_LW:   k = I_LW;
      OP_SW:   k = I_SW;
      OP_BEQ:  k = I_BEQ;
      OP_JAL:  k = I_JAL;
      default: k = I_NOP;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mips_mc_rf.sv
// 32x32 register file: two asynchronous read ports, one write port, $0 reads as zero.
module mips_mc_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  // NOTE: this array is cleared by reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mips_mc.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over one shared memory port with ready handshake.
module mips_mc #(
  parameter logic [31:0] RESET_PC = mips_mc_pkg::DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic [31:0]       wb_pc
);
  import mips_mc_pkg::*;

  state_e      state;
  instr_e      kind;
  alu_op_e     alu_op;
  logic [31:0] ir, a, b, alu_out, mdr, target, cur_pc;
  logic [31:0] sext_imm, zext_imm, opb, alu_res, wb_val;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  dest;

  assign kind     = classify(ir[31:26], ir[5:0]);
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign zext_imm = {16'h0000, ir[15:0]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alu_op = ADD;
    opb    = b;
    case (kind)
      I_RTYPE: begin
        if (ir[5:0] == FN_SUBU)      alu_op = SUB;
        else if (ir[5:0] == FN_ADDU) alu_op = ADD;
        else                         alu_op = PASS;
      end
      I_ORI:       begin alu_op = OR;  opb = zext_imm; end
      I_LUI:       begin alu_op = LUI; opb = zext_imm; end
      I_LW, I_SW:  opb = sext_imm;
      default:     ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ADD:     alu_res = a + opb;
      SUB:     alu_res = a - opb;
      OR:      alu_res = a | opb;
      LUI:     alu_res = {opb[15:0], 16'h0000};
      default: alu_res = opb;
    endcase
  end

  always_comb begin
    dest = ir[20:16];
    if (kind == I_RTYPE)   dest = ir[15:11];
    else if (kind == I_JAL) dest = 5'd31;
  end

  assign wb_val = (kind == I_LW) ? mdr : alu_out;

  mips_mc_rf u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (dest),
    .wdata  (wb_val),
    .raddr1 (ir[25:21]),
    .raddr2 (ir[20:16]),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      target  <= '0;
      cur_pc  <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          cur_pc <= pc;
          pc     <= pc + 32'd4;
          state  <= DECODE;
        end
        DECODE: begin
          a      <= rf_rdata1;
          b      <= rf_rdata2;
          target <= pc + (sext_imm << 2);
          if (kind == I_NOP) state <= FETCH;
          else               state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (kind)
            I_RTYPE, I_ORI, I_LUI: begin alu_out <= alu_res; state <= WB;  end
            I_LW, I_SW:            begin alu_out <= alu_res; state <= MEM; end
            I_BEQ: if (a == b) pc <= target;
            I_JR:  pc <= a;
            I_JAL: begin
              alu_out <= pc;
              pc      <= {pc[31:28], ir[25:0], 2'b00};
              state   <= WB;
            end
            default: ;
          endcase
        end
        MEM: if (mem_ready) begin
          if (kind == I_LW) begin
            mdr   <= mem_rdata;
            state <= WB;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Port outputs decode registered state; gating with reset abandons an access immediately.
  assign mem_req   = reset && (state == FETCH || state == MEM);
  assign mem_we    = reset && (state == MEM) && (kind == I_SW);
  assign mem_wdata = mem_we ? b : '0;

  always_comb begin
    mem_addr = '0;
    if (mem_req)
      mem_addr = (state == MEM) ? {alu_out[ADDR_W-1:2], 2'b00} : {pc[ADDR_W-1:2], 2'b00};
  end

  assign wb_en   = (state == WB);
  assign wb_reg  = wb_en ? dest   : '0;
  assign wb_data = wb_en ? wb_val : '0;
  assign wb_pc   = wb_en ? cur_pc : '0;

endmodule

// File: tb/tb_mips_mc.sv
// Directed bench for mips_mc: wait-state memory model, write-back trace monitor, hand-computed vectors.
module tb_mips_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, wb_data, wb_pc;
  logic        wb_en;
  logic [4:0]  wb_reg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int data_waits = 0;
  int wait_left = 0;

  logic [31:0] mem [4096];
  logic        is_data;

  typedef struct {
    int          c;
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] p;
  } wb_t;
  wb_t wbq [$];

  always #5 clk = ~clk;

  mips_mc #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .wb_pc     (wb_pc)
  );

  // Program lives at 0x3000 and up; anything below is data and sees data_waits stall cycles.
  assign is_data   = mem_addr < 32'h0000_3000;
  assign mem_ready = !(is_data && wait_left != 0);
  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_req && is_data) begin
      if (wait_left != 0) wait_left <= wait_left - 1;
    end else begin
      wait_left <= data_waits;
    end
  end

  always @(posedge clk)
    if (reset && mem_req && mem_we && mem_ready) mem[mem_addr[13:2]] = mem_wdata;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset)     wbq.delete();
    else if (wb_en) wbq.push_back('{cyc, wb_reg, wb_data, wb_pc});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step_to(input int k);
    int guard = 0;
    while (cyc < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("step_to_%0d", k), cyc, k);
  endtask

  task automatic check_wb(input int i, input int c, input logic [4:0] r,
                          input logic [31:0] d, input logic [31:0] p);
    if (i < wbq.size()) begin
      check($sformatf("wb%0d_cycle", i), wbq[i].c, c);
      check($sformatf("wb%0d_reg", i),   wbq[i].r, r);
      check($sformatf("wb%0d_data", i),  wbq[i].d, d);
      check($sformatf("wb%0d_pc", i),    wbq[i].p, p);
    end else begin
      check($sformatf("wb%0d_count", i), wbq.size(), i + 1);
    end
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic put(input int i, input logic [31:0] w);
    mem[12'hC00 + i] = w;
  endtask

  task automatic load_alu_mem();
    clear_mem();
    put(0, 32'h3401_1234);  // ori  $1,$0,0x1234
    put(1, 32'h3C02_ABCD);  // lui  $2,0xABCD
    put(2, 32'h0022_1821);  // addu $3,$1,$2
    put(3, 32'hAC03_0004);  // sw   $3,4($0)
    put(4, 32'h8C04_0004);  // lw   $4,4($0)
    put(5, 32'h1000_FFFF);  // beq  $0,$0,-1
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values and first fetch
    load_alu_mem();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    data_waits = 2;
    reset = 1'b1;
    #1;
    check("rel_mem_req", mem_req, 1'b1);
    check("rel_mem_we", mem_we, 1'b0);
    check("rel_mem_addr", mem_addr, 32'h0000_3000);

    // ALU chain finishes in 12 cycles, then sw/lw with 2 wait states each
    step_to(12);
    check("alu_chain_fetch_addr", mem_addr, 32'h0000_300C);
    for (int k = 15; k <= 17; k++) begin
      step_to(k);
      check($sformatf("sw_req_c%0d", k), mem_req, 1'b1);
      check($sformatf("sw_we_c%0d", k), mem_we, 1'b1);
      check($sformatf("sw_addr_c%0d", k), mem_addr, 32'h0000_0004);
      check($sformatf("sw_wdata_c%0d", k), mem_wdata, 32'hABCD_1234);
    end
    step_to(18);
    check("sw_stored_word", mem[1], 32'hABCD_1234);
    check("lw_fetch_addr", mem_addr, 32'h0000_3010);
    for (int k = 21; k <= 23; k += 2) begin
      step_to(k);
      check($sformatf("lw_we_c%0d", k), mem_we, 1'b0);
      check($sformatf("lw_addr_c%0d", k), mem_addr, 32'h0000_0004);
    end
    step_to(24);
    check("lw_wb_no_req", mem_req, 1'b0);
    step_to(25);
    check("after_lw_req", mem_req, 1'b1);
    check("after_lw_addr", mem_addr, 32'h0000_3014);
    step_to(30);
    check("alu_wb_count", wbq.size(), 4);
    check_wb(0, 3,  5'd1, 32'h0000_1234, 32'h0000_3000);
    check_wb(1, 7,  5'd2, 32'hABCD_0000, 32'h0000_3004);
    check_wb(2, 11, 5'd3, 32'hABCD_1234, 32'h0000_3008);
    check_wb(3, 24, 5'd4, 32'hABCD_1234, 32'h0000_3010);

    // Branches: not-taken beq $1,$2,+4 then taken beq $1,$1,-1 loop
    clear_mem();
    put(0, 32'h3401_1234);  // ori $1,$0,0x1234
    put(1, 32'h3C02_ABCD);  // lui $2,0xABCD
    put(2, 32'h1022_0004);  // beq $1,$2,+4
    put(3, 32'h1021_FFFF);  // beq $1,$1,-1
    data_waits = 0;
    restart();
    step_to(11);
    check("beq_nt_pc", pc, 32'h0000_300C);
    step_to(12);
    check("beq_t_fetch_pc", pc, 32'h0000_3010);
    step_to(14);
    check("beq_t_pc", pc, 32'h0000_300C);
    step_to(17);
    check("beq_loop_pc", pc, 32'h0000_300C);
    check("beq_wb_count", wbq.size(), 2);

    // jal / jr, $0 write, unknown encoding
    clear_mem();
    put(0, 32'h13E0_0001);  // beq  $31,$0,+1
    put(1, 32'h03E0_0008);  // jr   $31
    put(2, 32'h0C00_0C00);  // jal  0x0C00
    put(3, 32'h3400_5555);  // ori  $0,$0,0x5555
    put(4, 32'hFC00_0000);  // unknown
    put(5, 32'h0000_2821);  // addu $5,$0,$0
    put(6, 32'h1000_FFFF);  // beq  $0,$0,-1
    restart();
    step_to(3);
    check("beq_first_pc", pc, 32'h0000_3008);
    step_to(6);
    check("jal_pc", pc, 32'h0000_3000);
    step_to(10);
    check("beq_second_pc", pc, 32'h0000_3004);
    step_to(13);
    check("jr_pc", pc, 32'h0000_300C);
    step_to(19);
    check("unknown_req", mem_req, 1'b1);
    check("unknown_next_addr", mem_addr, 32'h0000_3014);
    step_to(30);
    check("jump_wb_count", wbq.size(), 3);
    check_wb(0, 6,  5'd31, 32'h0000_300C, 32'h0000_3008);
    check_wb(1, 16, 5'd0,  32'h0000_5555, 32'h0000_300C);
    check_wb(2, 22, 5'd5,  32'h0000_0000, 32'h0000_3014);

    // Reset asserted while the store waits on memory
    load_alu_mem();
    data_waits = 5;
    restart();
    step_to(16);
    check("midrst_pre_req", mem_req, 1'b1);
    check("midrst_pre_we", mem_we, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_req_drop", mem_req, 1'b0);
    check("midrst_we_drop", mem_we, 1'b0);
    check("midrst_pc", pc, 32'h0000_3000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_rel_pc", pc, 32'h0000_3000);
    check("midrst_rel_addr", mem_addr, 32'h0000_3000);
    check("midrst_store_abandoned", mem[1], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
